// File: rtl/multiplicador_entero_pkg.sv
// multiplicador_entero_pkg
//
// Shared definitions for the button-driven integer multiplier:
//   - ANCHO_DEF : default operand width in bits (product is twice as wide).
//   - estado_t  : top-level FSM state encoding (IDLE=0, RUN=1, DONE=2).
//   - accion_t  : decoded intent of the up/down buttons.
//   - decodifica: maps the raw up/down levels to an accion_t.
package multiplicador_entero_pkg;

    localparam int unsigned ANCHO_DEF = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        AccNada = 2'd0,
        AccSube = 2'd1,
        AccBaja = 2'd2
    } accion_t;

    // Both buttons pressed together cancel out, same as neither pressed.
    function automatic accion_t decodifica(input logic up, input logic down);
        accion_t res;
        case ({up, down})
            2'b10:   res = AccSube;
            2'b01:   res = AccBaja;
            default: res = AccNada;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multiplicador_serie.sv
// multiplicador_serie
//
// Sequential shift-add multiplication engine, one iteration per clock.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous active-high reset, aborts any running product
//   inicio   in   one-cycle start pulse; latches a and b on that edge
//   a        in   ANCHO-bit multiplicand
//   b        in   ANCHO-bit multiplier
//   producto out  2*ANCHO-bit accumulator value after the current iteration
//                 (combinational); the final product when fin is high
//   fin      out  high during the cycle whose rising edge completes the last
//                 iteration, so the caller can capture producto on that edge
module multiplicador_serie
    import multiplicador_entero_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [ANCHO-1:0]   a,
    input  logic [ANCHO-1:0]   b,
    output logic [2*ANCHO-1:0] producto,
    output logic               fin
);

    localparam int unsigned CW = $clog2(ANCHO + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);
    localparam logic [CW-1:0] PASO   = CW'(1);

    logic [2*ANCHO-1:0] mcand_q;
    logic [ANCHO-1:0]   mplier_q;
    logic [2*ANCHO-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               activo_q;
    logic [2*ANCHO-1:0] suma;

    // Accumulator after this iteration; exposed so the last one needs no extra cycle.
    always_comb begin
        suma = acc_q;
        if (mplier_q[0]) begin
            suma = acc_q + mcand_q;
        end
        producto = suma;
        fin      = activo_q && (cnt_q == ULTIMO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            activo_q <= 1'b0;
        end else if (inicio) begin
            mcand_q  <= {{ANCHO{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            activo_q <= 1'b1;
        end else if (activo_q) begin
            acc_q    <= suma;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + PASO;
            if (fin) begin
                activo_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multiplicador_entero.sv
// multiplicador_entero
//
// Front-panel unsigned integer multiplier. Two operands are dialled in with
// up/down (selector picks which one), and a rising edge on ok starts a
// shift-add multiplication in multiplicador_serie.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous active-high reset, highest priority
//   up       in   level; selected operand +1 per clock, saturating at max
//   down     in   level; selected operand -1 per clock, saturating at 0
//   selector in   0 = operand A (multiplicand), 1 = operand B (multiplier)
//   ok       in   start request, acted on at its rising edge only
//   operando out  selected operand, for display
//   producto out  result of the last completed multiplication
//   ocupado  out  high while a multiplication is running
//   listo    out  high while producto corresponds to the current operands
module multiplicador_entero
    import multiplicador_entero_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               up,
    input  logic               down,
    input  logic               selector,
    input  logic               ok,
    output logic [ANCHO-1:0]   operando,
    output logic [2*ANCHO-1:0] producto,
    output logic               ocupado,
    output logic               listo
);

    localparam logic [ANCHO-1:0] UNO    = ANCHO'(1);
    localparam logic [ANCHO-1:0] MAXIMO = {ANCHO{1'b1}};

    estado_t            estado_q, estado_d;
    logic [ANCHO-1:0]   a_q, a_d;
    logic [ANCHO-1:0]   b_q, b_d;
    logic [2*ANCHO-1:0] producto_q, producto_d;
    logic               listo_q, listo_d;
    logic               ok_q;

    accion_t            accion;
    logic [ANCHO-1:0]   sel_val;
    logic [ANCHO-1:0]   sel_next;
    logic               cambio;
    logic               inicio;
    logic [2*ANCHO-1:0] producto_serie;
    logic               fin_serie;

    multiplicador_serie #(
        .ANCHO (ANCHO)
    ) u_serie (
        .clock    (clock),
        .reset    (reset),
        .inicio   (inicio),
        .a        (a_q),
        .b        (b_q),
        .producto (producto_serie),
        .fin      (fin_serie)
    );

    // Saturating step of the selected operand; cambio only when a value really moves.
    always_comb begin
        accion   = decodifica(up, down);
        sel_val  = selector ? b_q : a_q;
        sel_next = sel_val;
        cambio   = 1'b0;
        case (accion)
            AccSube: begin
                if (sel_val != MAXIMO) begin
                    sel_next = sel_val + UNO;
                    cambio   = 1'b1;
                end
            end
            AccBaja: begin
                if (sel_val != '0) begin
                    sel_next = sel_val - UNO;
                    cambio   = 1'b1;
                end
            end
            default: begin
                sel_next = sel_val;
                cambio   = 1'b0;
            end
        endcase
    end

    // ok edges are ignored while running, but ok_q keeps tracking regardless.
    assign inicio = ok && !ok_q && (estado_q != StRun);

    always_comb begin
        estado_d   = estado_q;
        a_d        = a_q;
        b_d        = b_q;
        producto_d = producto_q;
        listo_d    = listo_q;
        case (estado_q)
            StIdle, StDone: begin
                if (inicio) begin
                    // A start wins over a simultaneous up/down.
                    estado_d = StRun;
                    listo_d  = 1'b0;
                end else if (cambio) begin
                    if (selector) begin
                        b_d = sel_next;
                    end else begin
                        a_d = sel_next;
                    end
                    estado_d = StIdle;
                    listo_d  = 1'b0;
                end
            end
            StRun: begin
                if (fin_serie) begin
                    estado_d   = StDone;
                    producto_d = producto_serie;
                    listo_d    = 1'b1;
                end
            end
            default: begin
                estado_d = StIdle;
                listo_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            producto_q <= '0;
            listo_q    <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            a_q        <= a_d;
            b_q        <= b_d;
            producto_q <= producto_d;
            listo_q    <= listo_d;
            ok_q       <= ok;
        end
    end

    assign operando = sel_val;
    assign producto = producto_q;
    assign ocupado  = (estado_q == StRun);
    assign listo    = listo_q;

endmodule

// File: tb/tb_multiplicador_entero.sv
// Self-checking bench for multiplicador_entero (default ANCHO = 4).
// Stimulus pushes expected products into a scoreboard; a negedge monitor pops
// and compares each time listo rises, including the completion cycle.
module tb_multiplicador_entero;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       selector = 1'b0;
    logic       ok = 1'b0;
    logic [3:0] operando;
    logic [7:0] producto;
    logic       ocupado;
    logic       listo;

    int n_tests = 0;
    int n_fail  = 0;
    int ciclo   = 0;

    logic [7:0] sb_prod[$];
    int         sb_ciclo[$];
    logic       listo_prev = 1'b0;

    multiplicador_entero #(
        .ANCHO (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .up       (up),
        .down     (down),
        .selector (selector),
        .ok       (ok),
        .operando (operando),
        .producto (producto),
        .ocupado  (ocupado),
        .listo    (listo)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    task automatic comprobar(input string nombre, input int actual, input int esperado);
        n_tests++;
        if (actual != esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nombre, actual, esperado, ciclo);
        end
    endtask

    // Monitor: every rising edge of listo must match the oldest scoreboard entry.
    always @(negedge clock) begin
        if (listo === 1'b1 && listo_prev !== 1'b1) begin
            if (sb_prod.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got producto %0d, expected no result", producto);
            end else begin
                logic [7:0] esp;
                int k;
                esp = sb_prod.pop_front();
                k = sb_ciclo.pop_front();
                comprobar("sb_producto", int'(producto), int'(esp));
                comprobar("sb_latencia", ciclo, k + 4);
                comprobar("sb_ocupado", int'(ocupado), 0);
            end
        end
        listo_prev = listo;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic marcar(input logic sel, input logic u, input logic d, input int n);
        selector = sel;
        up = u;
        down = d;
        repeat (n) tick();
        up = 1'b0;
        down = 1'b0;
    endtask

    // Pulse ok and follow the RUN period. With con_up, up is also high on the
    // start edge and during the run, while selector toggles.
    task automatic multiplica(input logic [7:0] esperado, input bit con_up);
        logic [3:0] antes;
        logic       sel0;
        antes = operando;
        sel0 = selector;
        ok = 1'b1;
        up = con_up;
        sb_prod.push_back(esperado);
        sb_ciclo.push_back(ciclo + 1);
        tick();
        comprobar("ocupado_inicio", int'(ocupado), 1);
        comprobar("listo_inicio", int'(listo), 0);
        if (con_up) comprobar("inicio_gana", int'(operando), int'(antes));
        for (int i = 1; i <= 4; i++) begin
            ok = 1'b0;
            if (con_up) begin
                up = (i <= 2);
                selector = ~selector;
            end
            tick();
            if (i < 4) comprobar("ocupado_run", int'(ocupado), 1);
        end
        up = 1'b0;
        selector = sel0;
        comprobar("ocupado_fin", int'(ocupado), 0);
        comprobar("listo_fin", int'(listo), 1);
    endtask

    initial begin
        int n_subidas;
        logic prev;
        tick();
        tick();
        comprobar("rst_producto", int'(producto), 0);
        comprobar("rst_ocupado", int'(ocupado), 0);
        comprobar("rst_listo", int'(listo), 0);
        comprobar("rst_operando", int'(operando), 0);
        reset = 1'b0;
        tick();

        // 5 * 2 = 10
        marcar(1'b0, 1'b1, 1'b0, 5);
        comprobar("a_cinco", int'(operando), 5);
        marcar(1'b1, 1'b1, 1'b0, 2);
        comprobar("b_dos", int'(operando), 2);
        multiplica(8'd10, 1'b0);

        // One up on B in DONE invalidates listo but keeps producto.
        marcar(1'b1, 1'b1, 1'b0, 1);
        comprobar("done_cambio_listo", int'(listo), 0);
        comprobar("done_cambio_prod", int'(producto), 10);
        comprobar("done_cambio_b", int'(operando), 3);

        // Saturation at the top, then 15 * 15 = 225.
        marcar(1'b0, 1'b1, 1'b0, 20);
        comprobar("a_sat_max", int'(operando), 15);
        marcar(1'b1, 1'b1, 1'b0, 20);
        comprobar("b_sat_max", int'(operando), 15);
        multiplica(8'd225, 1'b0);

        // Saturation at zero, then 0 * 13 = 0.
        marcar(1'b0, 1'b0, 1'b1, 20);
        comprobar("a_sat_min", int'(operando), 0);
        marcar(1'b1, 1'b0, 1'b1, 2);
        comprobar("b_trece", int'(operando), 13);
        multiplica(8'd0, 1'b0);

        // Both buttons together: no change.
        marcar(1'b1, 1'b1, 1'b1, 3);
        comprobar("up_down_juntos", int'(operando), 13);

        // ok held high for 12 clocks: exactly one run, 3 * 13 = 39.
        marcar(1'b0, 1'b1, 1'b0, 3);
        comprobar("a_tres", int'(operando), 3);
        ok = 1'b1;
        sb_prod.push_back(8'd39);
        sb_ciclo.push_back(ciclo + 1);
        n_subidas = 0;
        prev = ocupado;
        repeat (12) begin
            tick();
            if (ocupado && !prev) n_subidas++;
            prev = ocupado;
        end
        ok = 1'b0;
        tick();
        comprobar("ok_sostenido_runs", n_subidas, 1);
        comprobar("ok_sostenido_sb", sb_prod.size(), 0);

        // up toggling during RUN (and on the start edge) is ignored: 3 * 7 = 21.
        marcar(1'b1, 1'b0, 1'b1, 6);
        comprobar("b_siete", int'(operando), 7);
        multiplica(8'd21, 1'b1);
        tick();
        comprobar("run_b_congelado", int'(operando), 7);
        selector = 1'b0;
        #1;
        comprobar("run_a_congelado", int'(operando), 3);
        comprobar("run_listo_sigue", int'(listo), 1);

        // Reset on the second RUN cycle.
        ok = 1'b1;
        tick();
        ok = 1'b0;
        comprobar("pre_rst_ocupado", int'(ocupado), 1);
        tick();
        reset = 1'b1;
        tick();
        comprobar("rst_run_producto", int'(producto), 0);
        comprobar("rst_run_ocupado", int'(ocupado), 0);
        comprobar("rst_run_listo", int'(listo), 0);
        comprobar("rst_run_operando", int'(operando), 0);
        reset = 1'b0;
        tick();
        tick();
        comprobar("post_rst_ocupado", int'(ocupado), 0);
        comprobar("post_rst_producto", int'(producto), 0);

        // Engine is clean after an aborted run: 2 * 3 = 6.
        marcar(1'b0, 1'b1, 1'b0, 2);
        marcar(1'b1, 1'b1, 1'b0, 3);
        multiplica(8'd6, 1'b0);

        repeat (3) tick();
        comprobar("sb_vacio", sb_prod.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "timeout");
    end

endmodule
